// File: rtl/cond_pkg.sv
// Shared definitions for the condition-code unit:
// flag bit positions, condition field encodings, FSM states.
package cond_pkg;

  localparam int FLG_N = 4;
  localparam int FLG_Z = 3;
  localparam int FLG_F = 2;
  localparam int FLG_L = 1;
  localparam int FLG_C = 0;

  localparam logic [3:0] COND_EQ = 4'd0;
  localparam logic [3:0] COND_NE = 4'd1;
  localparam logic [3:0] COND_CS = 4'd2;
  localparam logic [3:0] COND_CC = 4'd3;
  localparam logic [3:0] COND_HI = 4'd4;
  localparam logic [3:0] COND_LS = 4'd5;
  localparam logic [3:0] COND_GT = 4'd6;
  localparam logic [3:0] COND_LE = 4'd7;
  localparam logic [3:0] COND_FS = 4'd8;
  localparam logic [3:0] COND_FC = 4'd9;
  localparam logic [3:0] COND_LO = 4'd10;
  localparam logic [3:0] COND_HS = 4'd11;
  localparam logic [3:0] COND_LT = 4'd12;
  localparam logic [3:0] COND_GE = 4'd13;
  localparam logic [3:0] COND_UC = 4'd14;
  localparam logic [3:0] COND_NV = 4'd15;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_e;

endpackage

// File: rtl/cond_eval.sv
// Pure condition evaluator: flags + 4-bit condition field -> true.
// Kept standalone so the controller can reuse it for flag-based stalls.
module cond_eval
  import cond_pkg::*;
(
  input  logic [4:0] flags_i,
  input  logic [3:0] cond_i,
  output logic       true_o
);

  logic n, z, f, l, c;

  assign n = flags_i[FLG_N];
  assign z = flags_i[FLG_Z];
  assign f = flags_i[FLG_F];
  assign l = flags_i[FLG_L];
  assign c = flags_i[FLG_C];

  // Decode the condition field against the flags.
  always_comb begin
    true_o = 1'b0;
    unique case (cond_i)
      COND_EQ: true_o = z;
      COND_NE: true_o = !z;
      COND_CS: true_o = c;
      COND_CC: true_o = !c;
      COND_HI: true_o = l;
      COND_LS: true_o = !l;
      COND_GT: true_o = n;
      COND_LE: true_o = !n;
      COND_FS: true_o = f;
      COND_FC: true_o = !f;
      COND_LO: true_o = !l && !z;
      COND_HS: true_o = l || z;
      COND_LT: true_o = !n && !z;
      COND_GE: true_o = n || z;
      COND_UC: true_o = 1'b1;
      COND_NV: true_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_unit.sv
// Processor status flags, branch condition resolution with a
// req/ack handshake, and a saturating taken-branch counter.
module cond_unit
  import cond_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alu_valid,
  input  logic             codes_computed,
  input  logic [4:0]       con_codes,
  input  logic             psr_we,
  input  logic [4:0]       psr_wdata,
  input  logic             br_req,
  input  logic [3:0]       br_cond,
  output logic             br_ack,
  output logic             br_taken,
  output logic [4:0]       psr_q,
  output logic             carry,
  output logic [CNT_W-1:0] taken_cnt,
  input  logic             cnt_clr
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q;
  logic             ack_q;
  logic             taken_q;
  logic [4:0]       flags_q;
  logic [4:0]       flags_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             cond_true;
  logic             accept;

  // Next flag value; also the bypassed flags used for evaluation.
  always_comb begin
    flags_d = flags_q;
    if (psr_we) begin
      flags_d = psr_wdata;
    end else if (alu_valid && codes_computed) begin
      flags_d = con_codes;
    end
  end

  cond_eval u_eval (
    .flags_i (flags_d),
    .cond_i  (br_cond),
    .true_o  (cond_true)
  );

  assign accept = (state_q == ST_IDLE) && br_req;

  // Saturating taken counter, clear wins over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (accept && cond_true && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
    end else begin
      flags_q <= flags_d;
    end
  end

  // Taken counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Handshake FSM with registered ack and taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
      taken_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (br_req) begin
            state_q <= ST_RESP;
            ack_q   <= 1'b1;
            taken_q <= cond_true;
          end else begin
            ack_q   <= 1'b0;
            taken_q <= 1'b0;
          end
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
          ack_q   <= 1'b0;
          taken_q <= 1'b0;
        end
      endcase
    end
  end

  assign br_ack    = ack_q;
  assign br_taken  = taken_q;
  assign psr_q     = flags_q;
  assign carry     = flags_q[FLG_C];
  assign taken_cnt = cnt_q;

endmodule

// File: tb/tb_cond_unit.sv
// Scoreboard bench for cond_unit: stimulus pushes expected acks,
// a negedge monitor pops and compares them.
module tb_cond_unit;

  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             alu_valid;
  logic             codes_computed;
  logic [4:0]       con_codes;
  logic             psr_we;
  logic [4:0]       psr_wdata;
  logic             br_req;
  logic [3:0]       br_cond;
  logic             br_ack;
  logic             br_taken;
  logic [4:0]       psr_q;
  logic             carry;
  logic [CNT_W-1:0] taken_cnt;
  logic             cnt_clr;

  typedef struct {
    logic taken;
    int   cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic prev_ack = 1'b0;

  cond_unit #(.CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .alu_valid      (alu_valid),
    .codes_computed (codes_computed),
    .con_codes      (con_codes),
    .psr_we         (psr_we),
    .psr_wdata      (psr_wdata),
    .br_req         (br_req),
    .br_cond        (br_cond),
    .br_ack         (br_ack),
    .br_taken       (br_taken),
    .psr_q          (psr_q),
    .carry          (carry),
    .taken_cnt      (taken_cnt),
    .cnt_clr        (cnt_clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  function automatic logic model(input logic [4:0] fl, input logic [3:0] c);
    logic n, z, f, l, cy;
    {n, z, f, l, cy} = fl;
    case (c)
      4'd0:    return z;
      4'd1:    return !z;
      4'd2:    return cy;
      4'd3:    return !cy;
      4'd4:    return l;
      4'd5:    return !l;
      4'd6:    return n;
      4'd7:    return !n;
      4'd8:    return f;
      4'd9:    return !f;
      4'd10:   return !l && !z;
      4'd11:   return l || z;
      4'd12:   return !n && !z;
      4'd13:   return n || z;
      4'd14:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Monitor: every ack must match the oldest expectation, in time.
  always @(negedge clk) begin
    if (rst_n) begin
      if (br_ack) begin
        if (exp_q.size() == 0) begin
          check("unexpected_ack", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("br_taken", int'(br_taken), int'(e.taken));
          check("ack_cycle", cyc, e.cyc);
        end
        if (prev_ack) check("ack_width", 2, 1);
      end else if (br_taken) begin
        check("taken_idle", 1, 0);
      end
      prev_ack = br_ack;
    end else begin
      prev_ack = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_ins();
    alu_valid      = 1'b0;
    codes_computed = 1'b0;
    con_codes      = '0;
    psr_we         = 1'b0;
    psr_wdata      = '0;
    br_req         = 1'b0;
    br_cond        = '0;
    cnt_clr        = 1'b0;
  endtask

  task automatic push(input logic t, input int at);
    exp_t e;
    e.taken = t;
    e.cyc   = at;
    exp_q.push_back(e);
  endtask

  // One request; flag inputs set by the caller apply in the same cycle.
  task automatic req(input logic [3:0] c, input logic t);
    br_req  = 1'b1;
    br_cond = c;
    push(t, cyc + 1);
    tick();
    clr_ins();
    tick();
  endtask

  task automatic wr_psr(input logic [4:0] v);
    psr_we    = 1'b1;
    psr_wdata = v;
    tick();
    clr_ins();
  endtask

  int k0;

  initial begin
    rst_n = 1'b0;
    clr_ins();
    tick();
    tick();
    check("rst_ack", int'(br_ack), 0);
    check("rst_taken", int'(br_taken), 0);
    check("rst_psr", int'(psr_q), 0);
    check("rst_carry", int'(carry), 0);
    check("rst_cnt", int'(taken_cnt), 0);
    rst_n = 1'b1;
    tick();

    // Reset mid-handshake aborts the pending ack.
    wr_psr(5'b11111);
    req(4'd14, 1'b1);
    check("pre_rst_cnt", int'(taken_cnt), 1);
    br_req  = 1'b1;
    br_cond = 4'd14;
    tick();
    br_req = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("midrst_ack", int'(br_ack), 0);
    check("midrst_psr", int'(psr_q), 0);
    check("midrst_cnt", int'(taken_cnt), 0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();

    // Bypass of ALU flags into the same-cycle evaluation.
    alu_valid      = 1'b1;
    codes_computed = 1'b1;
    con_codes      = 5'b01000;
    br_req         = 1'b1;
    br_cond        = 4'd0;
    push(1'b1, cyc + 1);
    tick();
    clr_ins();
    check("byp_psr", int'(psr_q), 5'b01000);
    tick();

    // Ops that do not define flags leave them alone.
    wr_psr(5'b00001);
    alu_valid = 1'b1;
    con_codes = 5'b00000;
    req(4'd2, 1'b1);
    check("noflag_psr", int'(psr_q), 5'b00001);
    check("noflag_carry", int'(carry), 1);
    req(4'd3, 1'b0);

    // Explicit write beats ALU update.
    psr_we         = 1'b1;
    psr_wdata      = 5'b10000;
    alu_valid      = 1'b1;
    codes_computed = 1'b1;
    con_codes      = 5'b01000;
    req(4'd6, 1'b1);
    check("prio_psr", int'(psr_q), 5'b10000);
    req(4'd0, 1'b0);

    // Flag write during RESP must not disturb the registered result.
    br_req  = 1'b1;
    br_cond = 4'd6;
    push(1'b1, cyc + 1);
    tick();
    clr_ins();
    psr_we    = 1'b1;
    psr_wdata = 5'b00000;
    tick();
    clr_ins();

    // Full table sweep via bypassed explicit writes.
    for (int f = 0; f < 32; f++) begin
      for (int c = 0; c < 16; c++) begin
        psr_we    = 1'b1;
        psr_wdata = 5'(f);
        req(4'(c), model(5'(f), 4'(c)));
      end
    end
    check("sweep_psr", int'(psr_q), 31);

    // Back-to-back held request: ack every second cycle, saturation.
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("clr_cnt0", int'(taken_cnt), 0);
    k0      = cyc;
    br_req  = 1'b1;
    br_cond = 4'd14;
    for (int i = 0; i < 5; i++) push(1'b1, k0 + 1 + 2 * i);
    repeat (9) tick();
    br_req = 1'b0;
    tick();
    check("sat_cnt", int'(taken_cnt), 3);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("clr_cnt", int'(taken_cnt), 0);

    // Clear wins over a same-cycle taken increment.
    cnt_clr = 1'b1;
    req(4'd14, 1'b1);
    check("clr_prio", int'(taken_cnt), 0);
    req(4'd14, 1'b1);
    check("inc_one", int'(taken_cnt), 1);

    repeat (4) tick();
    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
